usb_tx_sched: RTL

//  Packet-level scheduler in front of the USB transceiver TX path.
//  - Shares the single tx_data/tx_valid/tx_ready byte interface between N_REQ packet

---
 rtl/usb_tx_sched_if.sv | 24 ++
 rtl/usb_tx_sched.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/usb_tx_sched_if.sv
// Byte-stream bus between the packet sources, the TX scheduler and the transceiver.
// The scheduler sits on the slave modport; the sources plus transceiver drive the master side.
interface usb_tx_sched_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*8-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               rx_active;

    modport slave (
        input  req_valid, req_data, req_last, tx_ready, rx_active,
        output req_ready, tx_data, tx_valid
    );

    modport master (
        output req_valid, req_data, req_last, tx_ready, rx_active,
        input  req_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/usb_tx_sched.sv
// Packet scheduler in front of the USB transceiver TX path.
// Arbitrates N_REQ byte sources (index 0 highest priority), frames each packet with
// tx_valid, and holds off transmit during receive and for an inter-packet gap.
//
// state | meaning
// IDLE  | no owner; grants when rx is quiet, gap counter is 0 and a source is valid
// SEND  | owner's bytes go to the transceiver, one per tx_ready pulse
// DRAIN | packet truncated by underrun; owner's bytes are swallowed until its last byte
// GAP   | enforced idle time after EOP; rx_active restarts the count
module usb_tx_sched #(
    parameter int N_REQ      = 2,
    parameter int IPG_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    usb_tx_sched_if.slave    bus,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic             underrun
);
    localparam int            GW       = (IPG_CYCLES > 0) ? $clog2(IPG_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(IPG_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t           state;
    logic [GW-1:0]    gap;
    logic             last_q;
    logic             rx_q;
    logic [7:0]       tx_data_q;
    logic             tx_valid_q;

    logic [N_REQ-1:0] pick_oh;
    logic [N_REQ-1:0] sel_oh;
    logic [N_REQ-1:0] req_ready_c;
    logic [7:0]       sel_data;
    logic             sel_last;
    logic             sel_valid;
    logic             can_grant;

    // Lowest-index valid source wins arbitration
    always_comb begin
        pick_oh = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                pick_oh    = '0;
                pick_oh[i] = 1'b1;
            end
        end
    end

    // The rx_active falling cycle itself is blocked too; the gap load lands on that edge
    assign can_grant = (state == IDLE) && !bus.rx_active && !rx_q &&
                       (gap == '0) && (|bus.req_valid);

    // Byte mux: the candidate winner in IDLE, the current owner otherwise
    always_comb begin
        sel_oh    = (state == IDLE) ? pick_oh : grant;
        sel_data  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel_oh[i]) begin
                sel_data  = sel_data | bus.req_data[8*i +: 8];
                sel_last  = sel_last | bus.req_last[i];
                sel_valid = sel_valid | bus.req_valid[i];
            end
        end
    end

    // Byte acceptance towards the sources; only the owner (or winner-to-be) ever sees ready
    always_comb begin
        req_ready_c = '0;
        unique case (state)
            IDLE:    req_ready_c = can_grant ? pick_oh : '0;
            SEND:    req_ready_c = (bus.tx_ready && !last_q) ? (bus.req_valid & grant) : '0;
            DRAIN:   req_ready_c = bus.req_valid & grant;
            default: req_ready_c = '0;
        endcase
    end

    assign bus.req_ready = req_ready_c;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign busy          = (state != IDLE);

    // Scheduler state machine with registered transceiver-side outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            gap        <= '0;
            last_q     <= 1'b0;
            rx_q       <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            grant      <= '0;
            underrun   <= 1'b0;
        end else begin
            rx_q     <= bus.rx_active;
            underrun <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (can_grant) begin
                        tx_data_q  <= sel_data;
                        last_q     <= sel_last;
                        tx_valid_q <= 1'b1;
                        grant      <= pick_oh;
                        state      <= SEND;
                    end else if (rx_q && !bus.rx_active) begin
                        gap <= GAP_LOAD;
                    end else if ((gap != '0) && !bus.rx_active) begin
                        gap <= gap - GW'(1);
                    end
                end
                SEND: begin
                    if (bus.tx_ready) begin
                        if (last_q) begin
                            tx_valid_q <= 1'b0;
                            grant      <= '0;
                            gap        <= GAP_LOAD;
                            state      <= GAP;
                        end else if (sel_valid) begin
                            tx_data_q <= sel_data;
                            last_q    <= sel_last;
                        end else begin
                            underrun   <= 1'b1;
                            tx_valid_q <= 1'b0;
                            state      <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (sel_valid && sel_last) begin
                        grant <= '0;
                        gap   <= GAP_LOAD;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (bus.rx_active) begin
                        gap <= GAP_LOAD;
                    end else if (gap <= GW'(1)) begin
                        gap   <= '0;
                        state <= IDLE;
                    end else begin
                        gap <= gap - GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
